// File: rtl/result_serializer.sv
// rtl/result_serializer.sv - captures nine MAC results and streams the valid row_w x col_x sub-matrix over valid/ready.
// Optional build macro RSER_COLMAJOR_EN selects column-major emission order instead of row-major.
module result_serializer #(
    parameter int RES_W = 10
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic [9*RES_W-1:0] mac_res,
    input  logic [1:0]         row_w,
    input  logic [1:0]         col_x,
    input  logic               unload_res,
    input  logic               out_ready,
    output logic [RES_W-1:0]   data_out,
    output logic               out_valid,
    output logic               out_last,
    output logic               busy,
    output logic               done
);

    typedef enum logic [1:0] {ST_IDLE, ST_SEND, ST_DONE} state_t;

    state_t               state_q, state_d;
    logic                 unload_q;
    logic [9*RES_W-1:0]   shadow_q, shadow_d;
    logic [1:0]           rows_q, rows_d, cols_q, cols_d;
    logic [1:0]           r_q, r_d, c_q, c_d;
    logic [1:0]           nr, nc;
    logic [RES_W-1:0]     data_q, data_d;
    logic                 valid_q, valid_d;
    logic                 last_q, last_d;
    logic                 start;

    // Element k = r*3+c; indices beyond 8 cannot occur but decode to zero.
    function automatic logic [RES_W-1:0] pick(input logic [9*RES_W-1:0] sh,
                                              input logic [1:0] r,
                                              input logic [1:0] c);
        logic [3:0] idx;
        idx  = {2'b00, r} * 4'd3 + {2'b00, c};
        pick = '0;
        for (int k = 0; k < 9; k++) begin
            if (idx == 4'(k)) pick = sh[k*RES_W +: RES_W];
        end
    endfunction

    assign start = (state_q == ST_IDLE) && unload_res && !unload_q;

    always_comb begin
        state_d  = state_q;
        shadow_d = shadow_q;
        rows_d   = rows_q;
        cols_d   = cols_q;
        r_d      = r_q;
        c_d      = c_q;
        data_d   = data_q;
        valid_d  = valid_q;
        last_d   = last_q;
        nr       = r_q;
        nc       = c_q;
`ifdef RSER_COLMAJOR_EN
        if (r_q == rows_q - 2'd1) begin
            nr = 2'd0;
            nc = c_q + 2'd1;
        end else begin
            nr = r_q + 2'd1;
        end
`else
        if (c_q == cols_q - 2'd1) begin
            nc = 2'd0;
            nr = r_q + 2'd1;
        end else begin
            nc = c_q + 2'd1;
        end
`endif
        case (state_q)
            ST_IDLE: begin
                if (start) begin
                    shadow_d = mac_res;
                    rows_d   = row_w;
                    cols_d   = col_x;
                    r_d      = 2'd0;
                    c_d      = 2'd0;
                    if (row_w == 2'd0 || col_x == 2'd0) begin
                        state_d = ST_DONE;
                    end else begin
                        state_d = ST_SEND;
                        valid_d = 1'b1;
                        data_d  = mac_res[RES_W-1:0];
                        last_d  = (row_w == 2'd1) && (col_x == 2'd1);
                    end
                end
            end
            ST_SEND: begin
                if (valid_q && out_ready) begin
                    if (last_q) begin
                        state_d = ST_DONE;
                        valid_d = 1'b0;
                        last_d  = 1'b0;
                        data_d  = '0;
                    end else begin
                        r_d    = nr;
                        c_d    = nc;
                        data_d = pick(shadow_q, nr, nc);
                        last_d = (nr == rows_q - 2'd1) && (nc == cols_q - 2'd1);
                    end
                end
            end
            ST_DONE: begin
                state_d = ST_IDLE;
                r_d     = 2'd0;
                c_d     = 2'd0;
            end
            default: state_d = ST_IDLE;
        endcase
    end

    // unload_q resets high so a level already present at reset release is not an edge.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q  <= ST_IDLE;
            unload_q <= 1'b1;
            shadow_q <= '0;
            rows_q   <= 2'd0;
            cols_q   <= 2'd0;
            r_q      <= 2'd0;
            c_q      <= 2'd0;
            data_q   <= '0;
            valid_q  <= 1'b0;
            last_q   <= 1'b0;
        end else begin
            state_q  <= state_d;
            unload_q <= unload_res;
            shadow_q <= shadow_d;
            rows_q   <= rows_d;
            cols_q   <= cols_d;
            r_q      <= r_d;
            c_q      <= c_d;
            data_q   <= data_d;
            valid_q  <= valid_d;
            last_q   <= last_d;
        end
    end

    assign data_out  = data_q;
    assign out_valid = valid_q;
    assign out_last  = last_q;
    assign busy      = (state_q == ST_SEND);
    assign done      = (state_q == ST_DONE);

endmodule

// File: tb/tb_result_serializer.sv
// tb/tb_result_serializer.sv - directed self-checking bench for result_serializer.
module tb_result_serializer;

    localparam int RES_W = 10;

    logic               clk;
    logic               rst_n;
    logic [9*RES_W-1:0] mac_res;
    logic [1:0]         row_w;
    logic [1:0]         col_x;
    logic               unload_res;
    logic               out_ready;
    logic [RES_W-1:0]   data_out;
    logic               out_valid;
    logic               out_last;
    logic               busy;
    logic               done;

    int tests;
    int fails;
    int hs_cnt;
    int done_cnt;

    result_serializer #(.RES_W(RES_W)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .mac_res    (mac_res),
        .row_w      (row_w),
        .col_x      (col_x),
        .unload_res (unload_res),
        .out_ready  (out_ready),
        .data_out   (data_out),
        .out_valid  (out_valid),
        .out_last   (out_last),
        .busy       (busy),
        .done       (done)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(posedge clk) begin
        if (out_valid && out_ready) hs_cnt++;
        if (done) done_cnt++;
    end

    task automatic set_mac(input int base);
        for (int k = 0; k < 9; k++) mac_res[k*RES_W +: RES_W] = RES_W'(base + k);
    endtask

    task automatic test_reset;
        rst_n = 1'b0; unload_res = 1'b1; out_ready = 1'b1;
        row_w = 2'd3; col_x = 2'd3; set_mac(1);
        hs_cnt = 0; done_cnt = 0;
        repeat (2) @(negedge clk);
        tests++;
        if ({out_valid, out_last, busy, done, data_out} !== {4'b0, {RES_W{1'b0}}}) begin
            fails++;
            $display("FAIL reset_values got v%b l%b b%b d%b data %0d want all 0", out_valid, out_last, busy, done, data_out);
        end
        rst_n = 1'b1;
        repeat (4) @(negedge clk);
        tests++;
        if (out_valid !== 1'b0 || busy !== 1'b0 || hs_cnt != 0 || done_cnt != 0) begin
            fails++;
            $display("FAIL unload_high_at_release got v%b b%b hs %0d done %0d want no transaction", out_valid, busy, hs_cnt, done_cnt);
        end
        unload_res = 1'b0;
        @(negedge clk);
    endtask

    task automatic test_rowmajor_3x3;
        row_w = 2'd3; col_x = 2'd3; set_mac(1); out_ready = 1'b1;
        unload_res = 1'b1;
        @(negedge clk);
        unload_res = 1'b0;
        for (int i = 0; i < 9; i++) begin
            tests++;
            if (out_valid !== 1'b1 || busy !== 1'b1 || data_out !== RES_W'(i + 1) || out_last !== (i == 8)) begin
                fails++;
                $display("FAIL rm3x3_beat%0d got v%b b%b data %0d last %b want v1 b1 data %0d last %b", i, out_valid, busy, data_out, out_last, i + 1, i == 8);
            end
            @(negedge clk);
        end
        tests++;
        if (done !== 1'b1 || out_valid !== 1'b0 || busy !== 1'b0) begin
            fails++;
            $display("FAIL rm3x3_done got done %b v%b b%b want done 1 v0 b0", done, out_valid, busy);
        end
        @(negedge clk);
        tests++;
        if (done !== 1'b0) begin
            fails++;
            $display("FAIL rm3x3_done_pulse got done %b want 0", done);
        end
    endtask

    task automatic test_backpressure_2x3;
        int hs0;
        hs0 = hs_cnt;
        row_w = 2'd2; col_x = 2'd3; set_mac(1); out_ready = 1'b0;
        unload_res = 1'b1;
        @(negedge clk);
        unload_res = 1'b0;
        for (int i = 0; i < 6; i++) begin
            out_ready = 1'b1;
            tests++;
            if (out_valid !== 1'b1 || data_out !== RES_W'(i + 1) || out_last !== (i == 5)) begin
                fails++;
                $display("FAIL bp_beat%0d got v%b data %0d last %b want v1 data %0d last %b", i, out_valid, data_out, out_last, i + 1, i == 5);
            end
            @(negedge clk);
            if (i < 5) begin
                out_ready = 1'b0;
                tests++;
                if (out_valid !== 1'b1 || data_out !== RES_W'(i + 2)) begin
                    fails++;
                    $display("FAIL bp_stall%0d got v%b data %0d want v1 data %0d", i, out_valid, data_out, i + 2);
                end
                @(negedge clk);
                tests++;
                if (out_valid !== 1'b1 || data_out !== RES_W'(i + 2)) begin
                    fails++;
                    $display("FAIL bp_hold%0d got v%b data %0d want v1 data %0d", i, out_valid, data_out, i + 2);
                end
                set_mac(1);
            end
        end
        tests++;
        if (done !== 1'b1 || hs_cnt - hs0 != 6) begin
            fails++;
            $display("FAIL bp_handshakes got done %b hs %0d want done 1 hs 6", done, hs_cnt - hs0);
        end
        out_ready = 1'b1;
        @(negedge clk);
    endtask

    task automatic test_snapshot;
        row_w = 2'd1; col_x = 2'd3; set_mac(1); out_ready = 1'b1;
        unload_res = 1'b1;
        @(negedge clk);
        unload_res = 1'b0;
        mac_res = {9{10'h3FF}};
        row_w = 2'd3; col_x = 2'd3;
        for (int i = 0; i < 3; i++) begin
            tests++;
            if (out_valid !== 1'b1 || data_out !== RES_W'(i + 1) || out_last !== (i == 2)) begin
                fails++;
                $display("FAIL snap_beat%0d got v%b data %0d last %b want v1 data %0d last %b", i, out_valid, data_out, out_last, i + 1, i == 2);
            end
            @(negedge clk);
        end
        tests++;
        if (done !== 1'b1 || out_valid !== 1'b0) begin
            fails++;
            $display("FAIL snap_done got done %b v%b want done 1 v0", done, out_valid);
        end
        @(negedge clk);
    endtask

    task automatic test_zero_dim;
        int hs0;
        hs0 = hs_cnt;
        row_w = 2'd2; col_x = 2'd0; set_mac(1); out_ready = 1'b1;
        unload_res = 1'b1;
        @(negedge clk);
        unload_res = 1'b0;
        tests++;
        if (done !== 1'b1 || out_valid !== 1'b0 || busy !== 1'b0) begin
            fails++;
            $display("FAIL zero_done got done %b v%b b%b want done 1 v0 b0", done, out_valid, busy);
        end
        @(negedge clk);
        tests++;
        if (done !== 1'b0 || out_valid !== 1'b0 || hs_cnt != hs0) begin
            fails++;
            $display("FAIL zero_after got done %b v%b hs %0d want done 0 v0 hs 0", done, out_valid, hs_cnt - hs0);
        end
    endtask

    task automatic test_held_high;
        int hs0;
        int d0;
        hs0 = hs_cnt; d0 = done_cnt;
        row_w = 2'd1; col_x = 2'd2; set_mac(1); out_ready = 1'b1;
        unload_res = 1'b1;
        repeat (30) @(negedge clk);
        unload_res = 1'b0;
        repeat (3) @(negedge clk);
        tests++;
        if (hs_cnt - hs0 != 2 || done_cnt - d0 != 1) begin
            fails++;
            $display("FAIL held_high got hs %0d done %0d want hs 2 done 1", hs_cnt - hs0, done_cnt - d0);
        end
    endtask

    task automatic test_reset_midstream;
        int d0;
        row_w = 2'd3; col_x = 2'd3; set_mac(1); out_ready = 1'b1;
        unload_res = 1'b1;
        @(negedge clk);
        unload_res = 1'b0;
        @(negedge clk);
        d0 = done_cnt;
        #2 rst_n = 1'b0;
        #1;
        tests++;
        if (out_valid !== 1'b0 || busy !== 1'b0 || data_out !== '0 || out_last !== 1'b0) begin
            fails++;
            $display("FAIL reset_abort got v%b b%b data %0d last %b want all 0", out_valid, busy, data_out, out_last);
        end
        @(negedge clk);
        rst_n = 1'b1;
        repeat (12) @(negedge clk);
        tests++;
        if (done_cnt != d0 || out_valid !== 1'b0) begin
            fails++;
            $display("FAIL reset_no_done got done %0d v%b want done 0 v0", done_cnt - d0, out_valid);
        end
    endtask

    task automatic test_order_2x2;
        int exp_v[4];
`ifdef RSER_COLMAJOR_EN
        exp_v = '{10, 13, 11, 14};
`else
        exp_v = '{10, 11, 13, 14};
`endif
        row_w = 2'd2; col_x = 2'd2; set_mac(10); out_ready = 1'b1;
        unload_res = 1'b1;
        @(negedge clk);
        unload_res = 1'b0;
        for (int i = 0; i < 4; i++) begin
            tests++;
            if (out_valid !== 1'b1 || data_out !== RES_W'(exp_v[i]) || out_last !== (i == 3)) begin
                fails++;
                $display("FAIL order_beat%0d got v%b data %0d last %b want v1 data %0d last %b", i, out_valid, data_out, out_last, exp_v[i], i == 3);
            end
            @(negedge clk);
        end
        tests++;
        if (done !== 1'b1) begin
            fails++;
            $display("FAIL order_done got done %b want 1", done);
        end
        @(negedge clk);
    endtask

    initial begin
        tests = 0;
        fails = 0;
        mac_res = '0;
        test_reset;
        test_rowmajor_3x3;
        test_backpressure_2x3;
        test_snapshot;
        test_zero_dim;
        test_held_high;
        test_reset_midstream;
        test_order_2x2;
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
